byte_bus_bridge: RTL and testbench
==================================

Name: byte_bus_bridge

Overview:
Parametrised successor to the CPU-to-pin memory path. It accepts one word-wide memory request per transaction from the core over a valid/ready interface. Each request is serialised into byte beats on the 8-bit Tiny Tapeout pin bus: address on uo_out, write data on uio_out, per-byte output enable on uio_oe, and read data from uio_in. Read responses are reassembled into a word. Word width, address width and external read latency are configurable, and writes support byte strobes.

Parameters:
DATA_WIDTH, 32, core word width; multiple of BUS_WIDTH, 8..64
BUS_WIDTH, 8, pin data width
ADDR_WIDTH, 8, pin/byte address width
READ_LATENCY, 1, cycles from address driven to uio_in valid; 0..3
(local) BEATS = DATA_WIDTH/BUS_WIDTH

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  bridge can accept (IDLE only)
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte address of beat 0
req_wdata  in  DATA_WIDTH  write word; byte k = bits [8k+:8]
req_wstrb  in  BEATS  per-byte write enable
rsp_valid  out  1  one-cycle completion pulse (reads and writes)
rsp_rdata  out  DATA_WIDTH  assembled read word
bus_addr  out  ADDR_WIDTH  to uo_out
bus_wdata  out  BUS_WIDTH  to uio_out
bus_oe  out  BUS_WIDTH  to uio_oe
bus_rdata  in  BUS_WIDTH  from uio_in

Behaviour:
- Reset (async, rst_n low) forces, immediately:
  - state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0.
  - bus_addr=0, bus_wdata=0, bus_oe=0; all counters 0.
  - A transfer in progress is aborted; no rsp_valid is produced for it.
- States: IDLE, XFER.
- Acceptance:
  - req_ready=1 in IDLE only.
  - Acceptance occurs at edge E0 where req_valid&&req_ready.
  - addr, wdata, wstrb and write are captured at E0. Core inputs are don't-care afterwards.
- All bus_* outputs are registered. Cycle c is the cycle between edges Ec and Ec+1.
- Write transfer:
  - Beat k (0..BEATS-1) is driven in cycle k: bus_addr=addr+k, bus_wdata=wdata byte k, bus_oe={BUS_WIDTH{wstrb[k]}}.
  - Every beat consumes one cycle, including beats with a zero strobe. An all-zero wstrb still takes BEATS cycles with oe=0 throughout.
  - At E(BEATS): state=IDLE, bus_oe=0, bus_wdata=0, rsp_valid=1 for one cycle.
  - rsp_rdata is unchanged by writes.
- Read transfer:
  - bus_oe=0 and bus_wdata=0 throughout.
  - bus_addr=addr+k in cycle k for k<BEATS, then holds addr+BEATS-1.
  - Byte k is sampled from bus_rdata at edge E(k+READ_LATENCY+1) into rsp_rdata[8k+:8].
  - rsp_rdata bytes update during the transfer. They are valid as a word only when rsp_valid=1, and hold until the next read.
  - At E(BEATS+READ_LATENCY): state=IDLE, rsp_valid=1 for one cycle.
- Address arithmetic is modulo 2^ADDR_WIDTH. 0xFF+1 wraps to 0x00, silently.
- In IDLE, bus_addr holds the last driven address.
- Back-to-back:
  - req_ready is high in the rsp_valid cycle, so the earliest next acceptance is the edge ending that cycle.
  - No overlap between transactions.
- Response timing (BEATS=4, READ_LATENCY=1): write rsp_valid at E4 (4 cycles after accept); read rsp_valid at E5.
- rsp_valid is never high for two consecutive cycles.

Decomposition:
- Package byte_bus_bridge_pkg holds:
  - state enum (IDLE, XFER);
  - beats(DATA_WIDTH, BUS_WIDTH) function;
  - elaboration checks: DATA_WIDTH%BUS_WIDTH==0, READ_LATENCY<=3.
- Single module; one cycle counter of width clog2(BEATS+4). The issue index and sample index (cnt-READ_LATENCY) are both derived from this counter.
- No sub-module.

Test Plan:
- Async reset: pull rst_n low mid-cycle during a write beat -> bus_oe, bus_addr, bus_wdata and rsp_valid go to 0 before the next clk edge; req_ready=1.
- Full write: addr=0x10, wdata=0xDEADBEEF, wstrb=4'b1111 -> cycles 0..3 show addr 10,11,12,13, data EF,BE,AD,DE, oe FF; rsp_valid at E4 only; req_ready low in cycles 0..3.
- Strobed wrap write: addr=0xFE, wdata=0x44332211, wstrb=4'b0101 -> addr FE,FF,00,01; data 11,22,33,44; oe FF,00,FF,00.
- Read with latency 1: memory model returns addr^0xA5 one cycle late, addr=0x20 -> bus_oe stays 00; rsp_valid at E5; rsp_rdata=0x86878485.
- Back-to-back: req_valid held high for a read then a write -> second accept at the edge ending the first rsp_valid cycle; no idle bus cycles lost, no double pulse.
- Reset mid-read at cycle 2, release, then read 0x30 -> no rsp_valid for the aborted read; new read returns 0x96979495 at E5 after its accept.

Source files
------------

// File: rtl/byte_bus_bridge_pkg.sv
// Shared types and helpers for byte_bus_bridge.
//   state_e : transfer FSM states
//   beats() : number of pin-bus beats per core word
//   cfg_ok(): parameter legality for elaboration-time checking
package byte_bus_bridge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  function automatic int unsigned beats(int unsigned data_width, int unsigned bus_width);
    return data_width / bus_width;
  endfunction

  function automatic bit cfg_ok(int unsigned data_width, int unsigned bus_width,
                                int unsigned read_latency);
    return (bus_width != 0) && (data_width >= bus_width) &&
           ((data_width % bus_width) == 0) && (read_latency <= 3);
  endfunction

endpackage

// File: rtl/byte_bus_bridge.sv
// Serialises one core word request into byte beats on the pin bus and
// reassembles read bytes into a word.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid_i/req_ready_o core request handshake (ready only in IDLE)
//   req_write_i             1 = write, 0 = read
//   req_addr_i              byte address of beat 0
//   req_wdata_i/req_wstrb_i write word and per-byte strobes
//   rsp_valid_o             one-cycle completion pulse
//   rsp_rdata_o             assembled read word
//   bus_addr_o              pin address (uo_out)
//   bus_wdata_o/bus_oe_o    pin write data and output enable (uio_out/uio_oe)
//   bus_rdata_i             pin read data (uio_in)
module byte_bus_bridge
  import byte_bus_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    req_valid_i,
  output logic                                    req_ready_o,
  input  logic                                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]                   req_addr_i,
  input  logic [DATA_WIDTH-1:0]                   req_wdata_i,
  input  logic [beats(DATA_WIDTH, BUS_WIDTH)-1:0] req_wstrb_i,
  output logic                                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]                   rsp_rdata_o,
  output logic [ADDR_WIDTH-1:0]                   bus_addr_o,
  output logic [BUS_WIDTH-1:0]                    bus_wdata_o,
  output logic [BUS_WIDTH-1:0]                    bus_oe_o,
  input  logic [BUS_WIDTH-1:0]                    bus_rdata_i
);

  localparam int unsigned BEATS   = beats(DATA_WIDTH, BUS_WIDTH);
  localparam int unsigned CNT_W   = $clog2(BEATS + 4);
  localparam int unsigned LAST_WR = BEATS - 1;
  localparam int unsigned LAST_RD = BEATS + READ_LATENCY - 1;
  localparam logic [DATA_WIDTH-1:0] LANE_MASK = DATA_WIDTH'({BUS_WIDTH{1'b1}});

  if (!cfg_ok(DATA_WIDTH, BUS_WIDTH, READ_LATENCY)) begin : g_bad_cfg
    $error("byte_bus_bridge: DATA_WIDTH must be a multiple of BUS_WIDTH, READ_LATENCY <= 3");
  end

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BEATS-1:0]        wstrb_q, wstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [BUS_WIDTH-1:0]    bus_wdata_q, bus_wdata_d;
  logic [BUS_WIDTH-1:0]    bus_oe_q, bus_oe_d;

  // Beat issued in the next cycle, and the byte lane sampled at this edge.
  int                      issue_c;
  int                      samp_c;
  int unsigned             lane_sh_c;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_oe_q    <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_oe_q    <= bus_oe_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_oe_d    = bus_oe_q;
    issue_c     = int'(cnt_q) + 1;
    samp_c      = int'(cnt_q) - int'(READ_LATENCY);
    lane_sh_c   = 0;

    unique case (state_q)
      IDLE: begin
        // Accepting a request also launches beat 0 so it appears in cycle 0.
        if (req_valid_i) begin
          state_d    = XFER;
          cnt_d      = '0;
          write_d    = req_write_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          wstrb_d    = req_wstrb_i;
          bus_addr_d = req_addr_i;
          if (req_write_i) begin
            bus_wdata_d = req_wdata_i[BUS_WIDTH-1:0];
            bus_oe_d    = {BUS_WIDTH{req_wstrb_i[0]}};
          end else begin
            bus_wdata_d = '0;
            bus_oe_d    = '0;
          end
        end
      end

      XFER: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (write_q) begin
          if (cnt_q == CNT_W'(LAST_WR)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            bus_wdata_d = '0;
            bus_oe_d    = '0;
            rsp_valid_d = 1'b1;
          end else begin
            bus_addr_d  = addr_q + ADDR_WIDTH'(issue_c);
            bus_wdata_d = BUS_WIDTH'(wdata_q >> (issue_c * BUS_WIDTH));
            bus_oe_d    = {BUS_WIDTH{1'(wstrb_q >> issue_c)}};
          end
        end else begin
          // Address stops advancing after the last beat and holds.
          if (issue_c < int'(BEATS)) begin
            bus_addr_d = addr_q + ADDR_WIDTH'(issue_c);
          end
          if ((samp_c >= 0) && (samp_c < int'(BEATS))) begin
            lane_sh_c   = int'(samp_c) * BUS_WIDTH;
            rsp_rdata_d = (rsp_rdata_q & ~(LANE_MASK << lane_sh_c)) |
                          (DATA_WIDTH'(bus_rdata_i) << lane_sh_c);
          end
          if (cnt_q == CNT_W'(LAST_RD)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            rsp_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == IDLE);
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign bus_oe_o    = bus_oe_q;

endmodule

// File: tb/tb_byte_bus_bridge.sv
// Self-checking bench for byte_bus_bridge (32-bit word, 8-bit bus,
// 8-bit address, read latency 1). External memory returns addr ^ 0xA5
// one cycle after the address is driven.
module tb_byte_bus_bridge;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [7:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_oe;
  logic [7:0]  bus_rdata;
  logic [7:0]  mem_q;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] e_addr;  // expected bus_addr per beat, beat k in [8k+:8]
    logic [31:0] e_data;  // expected bus_wdata per beat
    logic [31:0] e_oe;    // expected bus_oe per beat
    logic [31:0] e_rd;    // expected rsp_rdata at rsp_valid
    logic [3:0]  lat;     // cycle index of rsp_valid after accept
  } vec_t;

  vec_t vecs[5];

  byte_bus_bridge #(
    .DATA_WIDTH  (32),
    .BUS_WIDTH   (8),
    .ADDR_WIDTH  (8),
    .READ_LATENCY(1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_write_i(req_write),
    .req_addr_i (req_addr),
    .req_wdata_i(req_wdata),
    .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .bus_addr_o (bus_addr),
    .bus_wdata_o(bus_wdata),
    .bus_oe_o   (bus_oe),
    .bus_rdata_i(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= bus_addr ^ 8'hA5;
  assign bus_rdata = mem_q;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic [31:0] ea,
                              input logic [31:0] ed, input logic [31:0] eo,
                              input logic [31:0] er, input logic [3:0] lat);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.wstrb = st;
    v.e_addr = ea; v.e_data = ed; v.e_oe = eo; v.e_rd = er; v.lat = lat;
    return v;
  endfunction

  // Issue one transaction and check every cycle up to one past rsp_valid.
  task automatic apply_vec(input vec_t v, input string tag);
    logic [31:0] t;
    logic [7:0]  ea, ed, eo;
    @(negedge clk);
    chk($sformatf("%s ready_idle", tag), 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wdata = v.wdata; req_wstrb = v.wstrb;
    @(posedge clk); #1;
    // Scramble inputs: they must have been captured at the accept edge.
    req_valid = 1'b0; req_write = ~v.write; req_addr = 8'h5A;
    req_wdata = 32'h0BADF00D; req_wstrb = 4'hA;
    for (int c = 0; c <= int'(v.lat); c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (c < 4) begin
        t = v.e_addr >> (8 * c); ea = t[7:0];
        t = v.e_data >> (8 * c); ed = t[7:0];
        t = v.e_oe   >> (8 * c); eo = t[7:0];
      end else begin
        ea = v.e_addr[31:24]; ed = 8'h00; eo = 8'h00;
      end
      chk($sformatf("%s c%0d bus_addr", tag, c), 64'(bus_addr), 64'(ea));
      chk($sformatf("%s c%0d bus_wdata", tag, c), 64'(bus_wdata), 64'(ed));
      chk($sformatf("%s c%0d bus_oe", tag, c), 64'(bus_oe), 64'(eo));
      chk($sformatf("%s c%0d rsp_valid", tag, c), 64'(rsp_valid), 64'(c == int'(v.lat)));
      chk($sformatf("%s c%0d req_ready", tag, c), 64'(req_ready), 64'(c == int'(v.lat)));
      if (c == int'(v.lat))
        chk($sformatf("%s rsp_rdata", tag), 64'(rsp_rdata), 64'(v.e_rd));
    end
    @(posedge clk); #1;
    chk($sformatf("%s rsp_valid_after", tag), 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    logic [31:0] t;
    vecs[0] = mk(1'b1, 8'h10, 32'hDEADBEEF, 4'b1111, 32'h13121110, 32'hDEADBEEF,
                 32'hFFFFFFFF, 32'h00000000, 4'd4);
    vecs[1] = mk(1'b1, 8'hFE, 32'h44332211, 4'b0101, 32'h0100FFFE, 32'h44332211,
                 32'h00FF00FF, 32'h00000000, 4'd4);
    vecs[2] = mk(1'b0, 8'h20, 32'h00000000, 4'b0000, 32'h23222120, 32'h00000000,
                 32'h00000000, 32'h86878485, 4'd5);
    vecs[3] = mk(1'b1, 8'h80, 32'h12345678, 4'b0000, 32'h83828180, 32'h12345678,
                 32'h00000000, 32'h86878485, 4'd4);
    vecs[4] = mk(1'b0, 8'hFE, 32'h00000000, 4'b0000, 32'h0100FFFE, 32'h00000000,
                 32'h00000000, 32'hA4A55A5B, 4'd5);

    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = '0;
    #12;
    chk("reset req_ready", 64'(req_ready), 64'(1));
    chk("reset rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset bus_addr", 64'(bus_addr), 64'(0));
    chk("reset bus_wdata", 64'(bus_wdata), 64'(0));
    chk("reset bus_oe", 64'(bus_oe), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 5; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Async reset in the middle of a write beat.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10;
    req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstwr c1 bus_addr", 64'(bus_addr), 64'(8'h11));
    chk("rstwr c1 bus_oe", 64'(bus_oe), 64'(8'hFF));
    #2; rst_n = 1'b0; #1;
    chk("rstwr bus_oe", 64'(bus_oe), 64'(0));
    chk("rstwr bus_addr", 64'(bus_addr), 64'(0));
    chk("rstwr bus_wdata", 64'(bus_wdata), 64'(0));
    chk("rstwr rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rstwr req_ready", 64'(req_ready), 64'(1));
    @(negedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rstwr post c%0d rsp_valid", c), 64'(rsp_valid), 64'(0));
      chk($sformatf("rstwr post c%0d bus_oe", c), 64'(bus_oe), 64'(0));
    end

    // Back-to-back: read 0x20 then write 0x40 with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h20;
    @(posedge clk); #1;
    req_write = 1'b1; req_addr = 8'h40; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      chk($sformatf("b2b c%0d rsp_valid", c), 64'(rsp_valid), 64'(c == 5 || c == 10));
      chk($sformatf("b2b c%0d req_ready", c), 64'(req_ready), 64'(c == 5 || c == 10));
      if (c <= 3) begin
        chk($sformatf("b2b c%0d rd bus_addr", c), 64'(bus_addr), 64'(8'h20 + 8'(c)));
        chk($sformatf("b2b c%0d rd bus_oe", c), 64'(bus_oe), 64'(0));
      end
      if (c >= 6 && c <= 9) begin
        t = 32'hCAFEF00D >> (8 * (c - 6));
        chk($sformatf("b2b c%0d wr bus_addr", c), 64'(bus_addr), 64'(8'h40 + 8'(c - 6)));
        chk($sformatf("b2b c%0d wr bus_wdata", c), 64'(bus_wdata), 64'(t[7:0]));
        chk($sformatf("b2b c%0d wr bus_oe", c), 64'(bus_oe), 64'(8'hFF));
      end
      if (c == 5 || c == 10)
        chk($sformatf("b2b c%0d rsp_rdata", c), 64'(rsp_rdata), 64'(32'h86878485));
      if (c == 6) req_valid = 1'b0;
    end
    @(posedge clk); #1;
    chk("b2b rsp_valid_after", 64'(rsp_valid), 64'(0));

    // Reset during a read at cycle 2, then a fresh read of 0x30.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h50;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstrd c2 bus_addr", 64'(bus_addr), 64'(8'h52));
    #2; rst_n = 1'b0; #1;
    chk("rstrd req_ready", 64'(req_ready), 64'(1));
    chk("rstrd rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rstrd rsp_rdata", 64'(rsp_rdata), 64'(0));
    @(negedge clk); #1; rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("rstrd post c%0d rsp_valid", c), 64'(rsp_valid), 64'(0));
    end
    apply_vec(mk(1'b0, 8'h30, 32'h0, 4'h0, 32'h33323130, 32'h0, 32'h0,
                 32'h96979495, 4'd5), "rd30");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
